// File: rtl/vc_output_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : vc_output_arbiter_if
//  Purpose  : Request/grant/credit bundle between the input ports, the
//             per-output arbiter and the downstream router stage.
//  Ports    : REQ/REQ_VC/REQ_TAIL  per-input request, VC and tail flag
//             IACK/ILCK            per-VC credit return and downstream lock
//             GNT/FIRE/OVCH/OLCK   grant, transfer strobe, VC, VC held
//             CREDIT_0/CREDIT_1    per-VC credit counts
//             ERR                  sticky credit protocol error
//  Modports : master = request/credit source, slave = arbiter
//  Revision : 1.0  initial release
// ============================================================================
interface vc_output_arbiter_if #(
  parameter int NPORTS = 5,
  parameter int CW     = 3
);
  logic [NPORTS-1:0] REQ;
  logic [NPORTS-1:0] REQ_VC;
  logic [NPORTS-1:0] REQ_TAIL;
  logic [1:0]        IACK;
  logic [1:0]        ILCK;
  logic [NPORTS-1:0] GNT;
  logic              FIRE;
  logic              OVCH;
  logic [1:0]        OLCK;
  logic [CW-1:0]     CREDIT_0;
  logic [CW-1:0]     CREDIT_1;
  logic              ERR;

  modport master (
    output REQ, REQ_VC, REQ_TAIL, IACK, ILCK,
    input  GNT, FIRE, OVCH, OLCK, CREDIT_0, CREDIT_1, ERR
  );

  modport slave (
    input  REQ, REQ_VC, REQ_TAIL, IACK, ILCK,
    output GNT, FIRE, OVCH, OLCK, CREDIT_0, CREDIT_1, ERR
  );
endinterface
`default_nettype wire

// File: rtl/vc_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vc_output_arbiter
//  Purpose  : Per-output-port wormhole arbiter for a 5-port, 2-VC mesh router.
//             Round-robin among eligible inputs, holds the grant from head to
//             tail flit, tracks downstream credits per VC and gates every
//             flit transfer on credit availability.
//  Ports    : clk  - clock, rising edge
//             RST  - asynchronous active-high reset
//             bus  - vc_output_arbiter_if.slave (requests, credits, grant,
//                    FIRE, OVCH, OLCK, credit counts, ERR)
//  Revision : 1.0  initial release
// ============================================================================
module vc_output_arbiter #(
  parameter int NPORTS   = 5,
  parameter int CRED_MAX = 4,
  parameter int CW       = 3
) (
  input  wire logic         clk,
  input  wire logic         RST,
  vc_output_arbiter_if.slave bus
);

  localparam int            C_PW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [CW-1:0] C_CRED_MAX = CW'(CRED_MAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [NPORTS-1:0]   r_gnt;
  logic [NPORTS-1:0]   w_gnt_nxt;
  logic [C_PW-1:0]     r_gidx;       // binary index of the granted input
  logic [C_PW-1:0]     w_gidx_nxt;
  logic                r_vc;         // VC latched at grant time
  logic                w_vc_nxt;
  logic [C_PW-1:0]     r_rr_ptr;
  logic [C_PW-1:0]     w_rr_ptr_nxt;
  logic [1:0][CW-1:0]  r_cred;
  logic [1:0][CW-1:0]  w_cred_nxt;
  logic                r_err;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [1:0]          w_cred_ok;    // VC has at least one credit
  logic [1:0]          w_ovf;        // credit return with counter already full
  logic [1:0]          w_unf;        // consume attempt with counter empty
  logic [NPORTS-1:0]   w_elig;
  logic                w_pick_vld;
  logic [C_PW-1:0]     w_pick_idx;
  logic                w_fire;
  logic                w_tail;

  // Per-VC credit counter next-state. A fire and a credit return on the same
  // VC cancel out; an overflowing return saturates and flags an error.
  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic w_dec;
    logic w_inc;

    assign w_cred_ok[v] = |r_cred[v];
    assign w_dec        = w_fire & (r_vc == 1'(v));
    assign w_inc        = bus.IACK[v];
    assign w_ovf[v]     = w_inc & ~w_dec & (r_cred[v] == C_CRED_MAX);
    assign w_unf[v]     = w_dec & ~w_inc & (r_cred[v] == '0);

    always_comb begin
      w_cred_nxt[v] = r_cred[v];
      if (w_inc && !w_dec && !w_ovf[v]) begin
        w_cred_nxt[v] = r_cred[v] + CW'(1);
      end else if (w_dec && !w_inc && !w_unf[v]) begin
        w_cred_nxt[v] = r_cred[v] - CW'(1);
      end
    end
  end

  // An input may win a new grant only if its VC has credit and is not locked
  // downstream. ILCK has no effect on a packet already in flight.
  for (genvar i = 0; i < NPORTS; i++) begin : g_elig
    assign w_elig[i] = bus.REQ[i]
                     & w_cred_ok[bus.REQ_VC[i]]
                     & ~bus.ILCK[bus.REQ_VC[i]];
  end

  // Round-robin pick: first eligible index at or after r_rr_ptr, wrapping.
  always_comb begin
    int j;
    j          = 0;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int k = 0; k < NPORTS; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NPORTS) begin
        j = j - NPORTS;
      end
      if (!w_pick_vld && w_elig[j]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = C_PW'(j);
      end
    end
  end

  // A flit moves only while busy, the granted input still presents a flit,
  // and the latched VC has a credit downstream.
  assign w_fire = (r_state == ST_BUSY) & (|(bus.REQ & r_gnt)) & w_cred_ok[r_vc];
  assign w_tail = |(bus.REQ_TAIL & r_gnt);

  // --------------------------------------------------------------------------
  // FSM next-state and grant bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gidx_nxt   = r_gidx;
    w_vc_nxt     = r_vc;
    w_rr_ptr_nxt = r_rr_ptr;

    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = NPORTS'(1) << w_pick_idx;
          w_gidx_nxt  = w_pick_idx;
          w_vc_nxt    = bus.REQ_VC[w_pick_idx];
        end
      end
      ST_BUSY: begin
        // Pointer moves only on release so the served input becomes lowest
        // priority for the next arbitration round.
        if (w_fire && w_tail) begin
          w_state_nxt  = ST_IDLE;
          w_gnt_nxt    = '0;
          w_gidx_nxt   = '0;
          w_vc_nxt     = 1'b0;
          w_rr_ptr_nxt = (r_gidx == C_PW'(NPORTS - 1)) ? '0 : r_gidx + C_PW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_gidx   <= '0;
      r_vc     <= 1'b0;
      r_rr_ptr <= '0;
      r_cred   <= {C_CRED_MAX, C_CRED_MAX};
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gidx   <= w_gidx_nxt;
      r_vc     <= w_vc_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_cred   <= w_cred_nxt;
      r_err    <= r_err | (|w_ovf) | (|w_unf);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.GNT      = r_gnt;
  assign bus.FIRE     = w_fire;
  assign bus.OVCH     = r_vc;
  assign bus.OLCK     = (r_state == ST_BUSY) ? (r_vc ? 2'b10 : 2'b01) : 2'b00;
  assign bus.CREDIT_0 = r_cred[0];
  assign bus.CREDIT_1 = r_cred[1];
  assign bus.ERR      = r_err;

endmodule
`default_nettype wire

// File: doc/vc_output_arbiter.md
Name: vc_output_arbiter

Overview:
- Per-output-port packet arbiter for the 5-port, 2-VC mesh router.
- Shares one output port among the 5 input ports using round-robin.
- Holds each grant from the head flit through the tail flit (wormhole lock).
- Tracks downstream buffer credits per VC from IACK pulses, and gates every flit transfer on credit availability.
- Drives the output mux select, OVALID and OVCH for the router's output stage.

Parameters:
- NPORTS, 5, number of requesting input ports.
- CRED_MAX, 4, downstream buffer depth per VC, which is also the credit reset value.
- CW, 3, credit counter width; must hold CRED_MAX.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ  in  NPORTS  per input: flit valid and destined for this output.
- REQ_VC  in  NPORTS  per input: VC of the requesting packet.
- REQ_TAIL  in  NPORTS  per input: presented flit is the tail.
- IACK  in  2  per-VC credit-return pulse from downstream, one credit per cycle high.
- ILCK  in  2  per-VC downstream lock; the VC accepts no new packet while high.
- GNT  out  NPORTS  one-hot registered grant (mux select).
- FIRE  out  1  a flit transfers this cycle; drives OVALID.
- OVCH  out  1  VC of the granted packet.
- OLCK  out  2  VC currently held by an in-flight packet.
- CREDIT_0  out  CW  credit count, VC0.
- CREDIT_1  out  CW  credit count, VC1.
- ERR  out  1  sticky: credit overflow or underflow attempt.

Behaviour:
- Reset values: GNT=0, FIRE=0, OVCH=0, OLCK=0, CREDIT_0=CREDIT_1=CRED_MAX, ERR=0, state=IDLE, rr_ptr=0.
- A reset asserted mid-packet abandons the packet; all state returns to reset values.
- Eligibility of input i: REQ[i] & (CREDIT[REQ_VC[i]]>0) & !ILCK[REQ_VC[i]].
- State IDLE:
  - If any input is eligible, pick the first eligible index at or after rr_ptr, wrapping modulo NPORTS.
  - Next cycle: GNT one-hot = that input, OVCH=its VC, OLCK[vc]=1, state=BUSY. Grant latency is 1 cycle.
  - If no input is eligible, remain in IDLE with GNT=0.
- State BUSY, granted input g, VC v:
  - FIRE is combinational: REQ[g] & (CREDIT[v]>0). It is never high in IDLE.
  - REQ_VC[g] is ignored while BUSY; the VC is latched at grant.
  - ILCK is ignored while BUSY; it only blocks new grants.
  - On FIRE & REQ_TAIL[g]: next cycle GNT=0, OLCK[v]=0, rr_ptr=(g+1) mod NPORTS, state=IDLE.
  - The earliest next grant is 2 cycles after the tail FIRE (1 idle cycle plus 1 grant cycle).
  - A single-flit packet (head is tail) fires once and releases.
  - If REQ[g] drops mid-packet, the grant is held and FIRE=0; no timeout.
- Credits, per VC:
  - next = CREDIT - (FIRE & OVCH==vc) + IACK[vc].
  - Simultaneous fire and IACK on the same VC: count unchanged.
  - IACK arriving with CREDIT==CRED_MAX and no fire: saturate at CRED_MAX and set ERR.
  - Underflow cannot occur because FIRE is gated by CREDIT>0; any attempt sets ERR.
  - ERR clears only on reset.
- rr_ptr updates only on packet release, never on grant. The input just served drops to lowest priority.
- Only one packet is granted per output at a time. The other VC is unused by this output until release; there is no VC interleaving.

Test Plan:
- Reset: RST pulse mid-BUSY → GNT=0, FIRE=0, OLCK=0, CREDIT_0=CREDIT_1=4, ERR=0 on the same cycle, asynchronously.
- Round-robin: REQ=5'b10101 held, all VC0, 1-flit packets with TAIL=1, IACK[0] every cycle → grant order 0,2,4,0,2; each grant is one FIRE pulse, with a 1-cycle gap between grants.
- Wormhole lock: input 1 sends a 4-flit VC1 packet while input 3 also requests → GNT=5'b00010 for all 4 FIREs; input 3 is granted only after the tail; OLCK=2'b10 during the packet.
- Credit stall: VC0, no IACK, 6-flit packet → 4 FIREs, CREDIT_0=0, FIRE low. One IACK[0] pulse → one more FIRE next cycle, with CREDIT_0 staying at 0 afterwards.
- Simultaneous events:
  - FIRE on VC1 plus IACK[1] in the same cycle at CREDIT_1=2 → CREDIT_1 stays 2.
  - IACK[0] at CREDIT_0=4 → CREDIT_0=4 and ERR=1, sticky.
- ILCK gating: ILCK=2'b01, input 0 requests VC0 and input 2 requests VC1 → input 2 is granted. Raising ILCK[1] during input 2's packet does not stall it.
